// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

   // Sequencer states of the fetch-side program counter.
   typedef enum logic [1:0] {
      PC_IDLE = 2'd0,
      PC_RUN  = 2'd1,
      PC_HALT = 2'd2
   } pc_state_t;

   // Working width for offset arithmetic; callers truncate back to their PC width.
   localparam int PC_MAXW = 32;

   // Adds a sign-extended offset to a zero-extended PC; wraps modulo 2^PC_MAXW.
   function automatic logic [PC_MAXW-1:0] pc_add_offset(
      input logic        [PC_MAXW-1:0] pc,
      input logic signed [PC_MAXW-1:0] off
   );
      return pc + $unsigned(off);
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Decoder/ALU/fetch-side signals of the program-counter unit.
interface pc_unit_if #(
   parameter int L    = 10,
   parameter int TSW  = 2,
   parameter int OFFW = 8
);
   logic                   Start;
   logic [L-1:0]           StartAddr;
   logic                   Halt;
   logic                   JmpEq;
   logic                   JmpNe;
   logic                   JmpAl;
   logic                   Call;
   logic                   Ret;
   logic                   Zero;
   logic [TSW-1:0]         TgtSel;
   logic                   TgtWrEn;
   logic                   OffsetEn;
   logic signed [OFFW-1:0] Offset;
   logic [L-1:0]           ProgCtr;
   logic                   Running;
   logic                   Done;
   logic                   StackErr;

   // Decoder / sequencer side.
   modport master (
      output Start, StartAddr, Halt, JmpEq, JmpNe, JmpAl, Call, Ret, Zero,
             TgtSel, TgtWrEn, OffsetEn, Offset,
      input  ProgCtr, Running, Done, StackErr
   );

   // Program-counter unit side.
   modport slave (
      input  Start, StartAddr, Halt, JmpEq, JmpNe, JmpAl, Call, Ret, Zero,
             TgtSel, TgtWrEn, OffsetEn, Offset,
      output ProgCtr, Running, Done, StackErr
   );
endinterface

// File: rtl/pc_ret_stack.sv
// Return-address stack: LIFO of SDEPTH entries, top readable combinationally.
module pc_ret_stack #(
   parameter int L      = 10,
   parameter int SDEPTH = 4
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         push,
   input  logic         pop,
   input  logic [L-1:0] din,
   output logic [L-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(SDEPTH + 1);
   localparam int IW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

   // Entry storage is not reset: an empty pointer makes its contents irrelevant.
   logic [L-1:0]  mem [2**IW];
   logic [PW-1:0] ptr;

   assign empty = (ptr == '0);
   assign full  = (ptr == PW'(SDEPTH));
   assign dout  = empty ? '0 : mem[IW'(ptr - PW'(1))];

   // Occupancy pointer: counts 0..SDEPTH; push wins if both are requested.
   always_ff @(posedge Clk) begin
      if (Reset)
         ptr <= '0;
      else if (push && !full)
         ptr <= ptr + PW'(1);
      else if (pop && !empty)
         ptr <= ptr - PW'(1);
   end

   // Write the pushed return address into the next free slot.
   always_ff @(posedge Clk) begin
      if (push && !full)
         mem[IW'(ptr)] <= din;
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter for the fetch stage: run/idle/halt sequencer, branch-target
// registers, conditional/unconditional jumps and call/return via a hardware stack.
module pc_unit
   import pc_pkg::*;
#(
   parameter int L      = 10,
   parameter int NREG   = 3,
   parameter int OFFW   = 8,
   parameter int SDEPTH = 4,
   parameter int TSW    = $clog2(NREG + 1)
) (
   input logic      Clk,
   input logic      Reset,
   pc_unit_if.slave bus
);
   pc_state_t    state_q, state_n;
   logic [L-1:0] pc_q, pc_n, pc_inc, tgt, tr_wdata, stk_top;
   // Indexed directly by TgtSel; slot 0 and slots above NREG are never written.
   logic [L-1:0] tr_q [2**TSW];
   logic         sel_valid, jmp_taken;
   logic         stk_push, stk_pop, stk_full, stk_empty;
   logic         err_q, err_set;

   assign pc_inc    = pc_q + L'(1);
   assign sel_valid = (bus.TgtSel != '0) && (int'(bus.TgtSel) <= NREG);
   assign tgt       = tr_q[bus.TgtSel];
   assign jmp_taken = bus.JmpAl | (bus.JmpEq & bus.Zero) | (bus.JmpNe & ~bus.Zero);
   assign tr_wdata  = bus.OffsetEn
                      ? L'(pc_add_offset(PC_MAXW'(pc_q), PC_MAXW'($signed(bus.Offset))))
                      : pc_q;

   assign bus.ProgCtr  = pc_q;
   assign bus.StackErr = err_q;

   pc_ret_stack #(
      .L      (L),
      .SDEPTH (SDEPTH)
   ) u_stack (
      .Clk   (Clk),
      .Reset (Reset),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (pc_inc),
      .dout  (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // Sequencer state register.
   always_ff @(posedge Clk) begin
      if (Reset)
         state_q <= PC_IDLE;
      else
         state_q <= state_n;
   end

   // Next state: Start launches from IDLE/HALT, Halt stops a running program.
   always_comb begin
      state_n = state_q;
      case (state_q)
         PC_IDLE, PC_HALT: if (bus.Start) state_n = PC_RUN;
         PC_RUN:           if (bus.Halt)  state_n = PC_HALT;
         default:          state_n = PC_IDLE;
      endcase
   end

   // Status outputs decoded from the registered state.
   always_comb begin
      bus.Running = (state_q == PC_RUN);
      bus.Done    = (state_q == PC_HALT);
   end

   // Next PC and stack control, priority Halt > Ret > Call > jump > increment.
   always_comb begin
      pc_n     = pc_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      err_set  = 1'b0;
      if (state_q == PC_RUN) begin
         if (bus.Halt) begin
            pc_n = pc_q;
         end else if (bus.Ret) begin
            if (!stk_empty) begin
               pc_n    = stk_top;
               stk_pop = 1'b1;
            end else begin
               err_set = 1'b1;
               pc_n    = pc_inc;
            end
         end else if (bus.Call && sel_valid) begin
            if (!stk_full) begin
               stk_push = 1'b1;
               pc_n     = tgt;
            end else begin
               err_set = 1'b1;
               pc_n    = pc_inc;
            end
         end else if (jmp_taken && sel_valid) begin
            pc_n = tgt;
         end else begin
            pc_n = pc_inc;
         end
      end else if (bus.Start) begin
         pc_n = bus.StartAddr;
      end
   end

   // PC register and sticky stack-error flag.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q <= pc_n;
         if (err_set)
            err_q <= 1'b1;
      end
   end

   // Branch-target registers; writable in any state, a same-cycle jump sees the old value.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int k = 0; k < 2**TSW; k++)
            tr_q[k] <= '0;
      end else if (bus.TgtWrEn && sel_valid) begin
         tr_q[bus.TgtSel] <= tr_wdata;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit (L=10, NREG=3, OFFW=8, SDEPTH=4).
module tb_pc_unit;
   localparam int L = 10, NREG = 3, OFFW = 8, SDEPTH = 4, TSW = 2;

   localparam int unsigned F_RST   = 1 << 0;
   localparam int unsigned F_START = 1 << 1;
   localparam int unsigned F_HALT  = 1 << 2;
   localparam int unsigned F_JEQ   = 1 << 3;
   localparam int unsigned F_JNE   = 1 << 4;
   localparam int unsigned F_JAL   = 1 << 5;
   localparam int unsigned F_CALL  = 1 << 6;
   localparam int unsigned F_RET   = 1 << 7;
   localparam int unsigned F_ZERO  = 1 << 8;
   localparam int unsigned F_WR    = 1 << 9;
   localparam int unsigned F_OE    = 1 << 10;

   typedef struct {
      int unsigned            ctl;
      logic [L-1:0]           saddr;
      logic [TSW-1:0]         sel;
      logic signed [OFFW-1:0] off;
      logic [L-1:0]           pc;
      logic                   run;
      logic                   done;
      logic                   err;
   } vec_t;

   logic Clk = 1'b0;
   logic Reset;
   int   total = 0;
   int   bad   = 0;
   vec_t tbl[$];

   pc_unit_if #(.L(L), .TSW(TSW), .OFFW(OFFW)) bus ();

   pc_unit #(
      .L      (L),
      .NREG   (NREG),
      .OFFW   (OFFW),
      .SDEPTH (SDEPTH),
      .TSW    (TSW)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   function automatic vec_t mk(input int unsigned ctl, input int saddr, input int sel,
                               input int off, input int pc, input bit run,
                               input bit done, input bit err);
      vec_t v;
      v.ctl   = ctl;
      v.saddr = L'(saddr);
      v.sel   = TSW'(sel);
      v.off   = OFFW'(off);
      v.pc    = L'(pc);
      v.run   = run;
      v.done  = done;
      v.err   = err;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input string tag);
      Reset         = (v.ctl & F_RST)   != 0;
      bus.Start     = (v.ctl & F_START) != 0;
      bus.Halt      = (v.ctl & F_HALT)  != 0;
      bus.JmpEq     = (v.ctl & F_JEQ)   != 0;
      bus.JmpNe     = (v.ctl & F_JNE)   != 0;
      bus.JmpAl     = (v.ctl & F_JAL)   != 0;
      bus.Call      = (v.ctl & F_CALL)  != 0;
      bus.Ret       = (v.ctl & F_RET)   != 0;
      bus.Zero      = (v.ctl & F_ZERO)  != 0;
      bus.TgtWrEn   = (v.ctl & F_WR)    != 0;
      bus.OffsetEn  = (v.ctl & F_OE)    != 0;
      bus.StartAddr = v.saddr;
      bus.TgtSel    = v.sel;
      bus.Offset    = v.off;
      @(posedge Clk);
      #1;
      chk($sformatf("%s pc", tag),      int'(bus.ProgCtr),  int'(v.pc));
      chk($sformatf("%s running", tag), int'(bus.Running),  int'(v.run));
      chk($sformatf("%s done", tag),    int'(bus.Done),     int'(v.done));
      chk($sformatf("%s stackerr", tag), int'(bus.StackErr), int'(v.err));
   endtask

   initial begin
      // Start, count, halt, strobes ignored while halted (TR3 write still lands)
      tbl.push_back(mk(F_START, 'h010, 0, 0, 'h010, 1, 0, 0));  // 0
      tbl.push_back(mk(0,       0,     0, 0, 'h011, 1, 0, 0));  // 1
      tbl.push_back(mk(0,       0,     0, 0, 'h012, 1, 0, 0));  // 2
      tbl.push_back(mk(F_HALT,  0,     0, 0, 'h012, 0, 1, 0));  // 3
      tbl.push_back(mk(F_WR | F_OE, 0, 3, 1, 'h012, 0, 1, 0));  // 4 TR3=013
      tbl.push_back(mk(F_JAL,   0,     1, 0, 'h012, 0, 1, 0));  // 5
      // Offset target write and conditional jumps
      tbl.push_back(mk(F_START, 'h020, 0, 0, 'h020, 1, 0, 0));  // 6
      tbl.push_back(mk(F_WR | F_OE, 0, 1, -4, 'h021, 1, 0, 0)); // 7 TR1=01C
      tbl.push_back(mk(F_JNE,   0,     1, 0, 'h01C, 1, 0, 0));  // 8
      tbl.push_back(mk(F_JEQ,   0,     1, 0, 'h01D, 1, 0, 0));  // 9
      tbl.push_back(mk(F_JEQ | F_ZERO, 0, 1, 0, 'h01C, 1, 0, 0)); // 10
      tbl.push_back(mk(F_JAL,   0,     0, 0, 'h01D, 1, 0, 0));  // 11 sel 0
      tbl.push_back(mk(F_JAL,   0,     3, 0, 'h013, 1, 0, 0));  // 12
      // Wrap-around of increment and offset add
      tbl.push_back(mk(F_HALT,  0,     0, 0, 'h013, 0, 1, 0));  // 13
      tbl.push_back(mk(F_START, 'h3FE, 0, 0, 'h3FE, 1, 0, 0));  // 14
      tbl.push_back(mk(F_WR | F_OE, 0, 2, 5, 'h3FF, 1, 0, 0));  // 15 TR2=003
      tbl.push_back(mk(0,       0,     0, 0, 'h000, 1, 0, 0));  // 16
      tbl.push_back(mk(F_JAL,   0,     2, 0, 'h003, 1, 0, 0));  // 17
      tbl.push_back(mk(F_WR,    0,     1, 0, 'h004, 1, 0, 0));  // 18 TR1=003
      tbl.push_back(mk(F_JAL,   0,     1, 0, 'h003, 1, 0, 0));  // 19
      // Write and jump to the same register: old value used
      tbl.push_back(mk(F_WR | F_OE | F_JAL, 0, 1, 16, 'h003, 1, 0, 0)); // 20 TR1=013
      tbl.push_back(mk(F_JAL,   0,     1, 0, 'h013, 1, 0, 0));  // 21
      // Halt beats Call/Jump: no push (otherwise overflow comes one call early)
      tbl.push_back(mk(F_HALT | F_CALL | F_JAL, 0, 2, 0, 'h013, 0, 1, 0)); // 22
      tbl.push_back(mk(F_START, 'h100, 0, 0, 'h100, 1, 0, 0));  // 23
      tbl.push_back(mk(F_WR,    0,     2, 0, 'h101, 1, 0, 0));  // 24 TR2=100
      // Fill the stack, overflow, unwind in LIFO order, underflow
      tbl.push_back(mk(F_CALL,  0,     2, 0, 'h100, 1, 0, 0));  // 25 push 102
      tbl.push_back(mk(F_CALL,  0,     1, 0, 'h013, 1, 0, 0));  // 26 push 101
      tbl.push_back(mk(F_CALL,  0,     3, 0, 'h013, 1, 0, 0));  // 27 push 014
      tbl.push_back(mk(0,       0,     0, 0, 'h014, 1, 0, 0));  // 28
      tbl.push_back(mk(F_CALL,  0,     2, 0, 'h100, 1, 0, 0));  // 29 push 015
      tbl.push_back(mk(F_CALL,  0,     2, 0, 'h101, 1, 0, 1));  // 30 overflow
      tbl.push_back(mk(F_RET,   0,     0, 0, 'h015, 1, 0, 1));  // 31
      tbl.push_back(mk(F_RET,   0,     0, 0, 'h014, 1, 0, 1));  // 32
      tbl.push_back(mk(F_RET,   0,     0, 0, 'h101, 1, 0, 1));  // 33
      tbl.push_back(mk(F_RET,   0,     0, 0, 'h102, 1, 0, 1));  // 34
      tbl.push_back(mk(F_RET,   0,     0, 0, 'h103, 1, 0, 1));  // 35 underflow
      tbl.push_back(mk(F_CALL,  0,     2, 0, 'h100, 1, 0, 1));  // 36 push 104
      tbl.push_back(mk(F_RET,   0,     0, 0, 'h104, 1, 0, 1));  // 37
      tbl.push_back(mk(F_CALL,  0,     2, 0, 'h100, 1, 0, 1));  // 38 push 105
      // Mid-run reset clears everything
      tbl.push_back(mk(F_RST | F_JAL, 0, 1, 0, 'h000, 0, 0, 0)); // 39
      tbl.push_back(mk(F_JAL,   0,     1, 0, 'h000, 0, 0, 0));  // 40
      tbl.push_back(mk(F_START, 'h200, 0, 0, 'h200, 1, 0, 0));  // 41
      tbl.push_back(mk(F_RET,   0,     0, 0, 'h201, 1, 0, 1));  // 42
      tbl.push_back(mk(F_JAL,   0,     2, 0, 'h000, 1, 0, 1));  // 43 TR2 reset
      tbl.push_back(mk(F_START, 'h3AA, 0, 0, 'h001, 1, 0, 1));  // 44 ignored
      tbl.push_back(mk(F_JNE | F_ZERO, 0, 1, 0, 'h002, 1, 0, 1)); // 45
      tbl.push_back(mk(F_JNE,   0,     1, 0, 'h000, 1, 0, 1));  // 46

      // Power-on reset
      step(mk(F_RST, 0, 0, 0, 'h000, 0, 0, 0), "reset0");
      step(mk(F_RST, 0, 0, 0, 'h000, 0, 0, 0), "reset1");

      foreach (tbl[i])
         step(tbl[i], $sformatf("row%0d", i));

      // Reset outranks Start; pushed return address wraps 3FF -> 000
      step(mk(F_RST | F_START, 'h155, 0, 0, 'h000, 0, 0, 0), "h_rst_start");
      step(mk(F_START, 'h155, 0, 0, 'h155, 1, 0, 0), "h_start");
      step(mk(F_WR,    0,     1, 0, 'h156, 1, 0, 0), "h_wr_tr1");
      step(mk(F_HALT,  0,     0, 0, 'h156, 0, 1, 0), "h_halt");
      step(mk(F_START, 'h3FF, 0, 0, 'h3FF, 1, 0, 0), "h_start_top");
      step(mk(F_CALL,  0,     1, 0, 'h155, 1, 0, 0), "h_call_wrap");
      step(mk(F_RET,   0,     0, 0, 'h000, 1, 0, 0), "h_ret_wrap");
      step(mk(F_RET,   0,     0, 0, 'h001, 1, 0, 1), "h_ret_empty");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
